// File: rtl/asrm_bus_pkg.sv
// asrm system bus: shared encodings for the two-master arbiter.
// Holds the FSM state, bus-owner tags and the default bus width.
package asrm_bus_pkg;

    localparam int WORDSIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_t;

endpackage

// File: rtl/asrm_bus_arbiter.sv
// asrm two-master bus arbiter: round-robin with bounded hold,
// registered grants, bus mux and one-cycle read-data return.
module asrm_bus_arbiter
    import asrm_bus_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [WORDSIZE-1:0] m0_addr,
    input  logic                m0_write_en,
    input  logic [WORDSIZE-1:0] m0_data_out,
    output logic                m0_grant,
    output logic [WORDSIZE-1:0] m0_data_in,
    input  logic                m1_req,
    input  logic [WORDSIZE-1:0] m1_addr,
    input  logic                m1_write_en,
    input  logic [WORDSIZE-1:0] m1_data_out,
    output logic                m1_grant,
    output logic [WORDSIZE-1:0] m1_data_in,
    output logic [WORDSIZE-1:0] bus_addr,
    output logic                bus_write_en,
    output logic [WORDSIZE-1:0] bus_data_out,
    input  logic [WORDSIZE-1:0] bus_data_in
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = '1;

    arb_state_t    state, state_n;
    logic          last;
    logic [HW-1:0] hold;
    owner_t        owner_d, owner_n;
    logic          drive0, drive1, contend;

    assign drive0  = (state == OWN0) && m0_req;
    assign drive1  = (state == OWN1) && m1_req;
    assign contend = ((state == OWN0) && m1_req) ||
                     ((state == OWN1) && m0_req);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_n = last ? OWN0 : OWN1;
                else if (m0_req)
                    state_n = OWN0;
                else if (m1_req)
                    state_n = OWN1;
            end
            OWN0: begin
                if (!m0_req)
                    state_n = m1_req ? OWN1 : IDLE;
                else if (m1_req && hold == HOLD_LAST)
                    state_n = OWN1;
            end
            OWN1: begin
                if (!m1_req)
                    state_n = m0_req ? OWN0 : IDLE;
                else if (m0_req && hold == HOLD_LAST)
                    state_n = OWN0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            if (state_n == OWN0)
                last <= 1'b0;
            else if (state_n == OWN1)
                last <= 1'b1;
        end
    end

    // hold counts contended cycles of the current tenure only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hold <= '0;
        else if (state_n != state)
            hold <= '0;
        else if (contend && hold != HOLD_SAT)
            hold <= hold + 1'b1;
    end

    always_comb begin
        owner_n = OWNER_NONE;
        if (drive0)
            owner_n = OWNER_M0;
        else if (drive1)
            owner_n = OWNER_M1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            owner_d <= OWNER_NONE;
        else
            owner_d <= owner_n;
    end

    always_comb begin
        bus_addr     = '0;
        bus_write_en = 1'b0;
        bus_data_out = '0;
        if (drive0) begin
            bus_addr     = m0_addr;
            bus_write_en = m0_write_en;
            bus_data_out = m0_data_out;
        end else if (drive1) begin
            bus_addr     = m1_addr;
            bus_write_en = m1_write_en;
            bus_data_out = m1_data_out;
        end
    end

    assign m0_grant   = (state == OWN0);
    assign m1_grant   = (state == OWN1);
    assign m0_data_in = (owner_d == OWNER_M0) ? bus_data_in : '0;
    assign m1_data_in = (owner_d == OWNER_M1) ? bus_data_in : '0;

endmodule

// File: tb/tb_asrm_bus_arbiter.sv
// Directed bench for asrm_bus_arbiter with a small ROM/GPIO slave model.
module tb_asrm_bus_arbiter;

    typedef struct packed {
        logic       m0r;
        logic [7:0] m0a;
        logic       m0w;
        logic [7:0] m0d;
        logic       m1r;
        logic [7:0] m1a;
        logic       m1w;
        logic [7:0] m1d;
        logic       eg0;
        logic       eg1;
        logic [7:0] ea;
        logic       ew;
        logic [7:0] ed;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] eio;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       mdl_init;
    logic       m0_req, m0_write_en, m1_req, m1_write_en;
    logic [7:0] m0_addr, m0_data_out, m1_addr, m1_data_out;
    logic       m0_grant, m1_grant, bus_write_en;
    logic [7:0] m0_data_in, m1_data_in, bus_addr, bus_data_out;
    logic [7:0] bus_data_in;
    logic [7:0] gpio_q;

    logic       h_g0, h_g1, h_bwe;
    logic [7:0] h_d0, h_d1, h_ba, h_bdo;

    int checks = 0;
    int failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    asrm_bus_arbiter #(.WORDSIZE(8), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr),
        .m0_write_en(m0_write_en), .m0_data_out(m0_data_out),
        .m0_grant(m0_grant), .m0_data_in(m0_data_in),
        .m1_req(m1_req), .m1_addr(m1_addr),
        .m1_write_en(m1_write_en), .m1_data_out(m1_data_out),
        .m1_grant(m1_grant), .m1_data_in(m1_data_in),
        .bus_addr(bus_addr), .bus_write_en(bus_write_en),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
    );

    asrm_bus_arbiter #(.WORDSIZE(8), .MAX_HOLD(1)) dut_h1 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr),
        .m0_write_en(m0_write_en), .m0_data_out(m0_data_out),
        .m0_grant(h_g0), .m0_data_in(h_d0),
        .m1_req(m1_req), .m1_addr(m1_addr),
        .m1_write_en(m1_write_en), .m1_data_out(m1_data_out),
        .m1_grant(h_g1), .m1_data_in(h_d1),
        .bus_addr(h_ba), .bus_write_en(h_bwe),
        .bus_data_out(h_bdo), .bus_data_in(bus_data_in)
    );

    // Synchronous slaves: GPIO register at 8'h80, ROM returns addr*20.
    always @(posedge clk) begin
        if (mdl_init) begin
            gpio_q      <= 8'h00;
            bus_data_in <= 8'h00;
        end else begin
            if (bus_write_en && bus_addr == 8'h80)
                gpio_q <= bus_data_out;
            bus_data_in <= (bus_addr == 8'h80) ? gpio_q
                                               : 8'(bus_addr * 8'd20);
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [7:0] a0,
                         input logic w0, input logic [7:0] d0,
                         input logic r1, input logic [7:0] a1,
                         input logic w1, input logic [7:0] d1);
        m0_req = r0; m0_addr = a0; m0_write_en = w0; m0_data_out = d0;
        m1_req = r1; m1_addr = a1; m1_write_en = w1; m1_data_out = d1;
    endtask

    function automatic vec_t mk(
        input logic r0, input logic [7:0] a0,
        input logic w0, input logic [7:0] d0,
        input logic r1, input logic [7:0] a1,
        input logic w1, input logic [7:0] d1,
        input logic g0, input logic g1, input logic [7:0] ea,
        input logic ew, input logic [7:0] ed, input logic [7:0] e0,
        input logic [7:0] e1, input logic [7:0] eio);
        vec_t v;
        v = '{r0, a0, w0, d0, r1, a1, w1, d1,
              g0, g1, ea, ew, ed, e0, e1, eio};
        return v;
    endfunction

    initial begin
        // single master write, read-back, idle return
        vq.push_back(mk(0,8'h00,0,8'h00, 0,8'h00,0,8'h00,
                        0,0,8'h00,0,8'h00,8'h00,8'h00,8'h00));
        vq.push_back(mk(1,8'h80,1,8'h5A, 0,8'h00,0,8'h00,
                        0,0,8'h00,0,8'h00,8'h00,8'h00,8'h00));
        vq.push_back(mk(1,8'h80,1,8'h5A, 0,8'h00,0,8'h00,
                        1,0,8'h80,1,8'h5A,8'h00,8'h00,8'h00));
        vq.push_back(mk(1,8'h80,0,8'h00, 0,8'h00,0,8'h00,
                        1,0,8'h80,0,8'h00,8'h00,8'h00,8'h5A));
        vq.push_back(mk(0,8'h00,0,8'h00, 0,8'h00,0,8'h00,
                        1,0,8'h00,0,8'h00,8'h5A,8'h00,8'h5A));
        vq.push_back(mk(0,8'h00,0,8'h00, 0,8'h00,0,8'h00,
                        0,0,8'h00,0,8'h00,8'h00,8'h00,8'h5A));
        // m1 alone from idle
        vq.push_back(mk(0,8'h00,0,8'h00, 1,8'h05,0,8'h00,
                        0,0,8'h00,0,8'h00,8'h00,8'h00,8'h5A));
        vq.push_back(mk(0,8'h00,0,8'h00, 1,8'h05,0,8'h00,
                        0,1,8'h05,0,8'h00,8'h00,8'h00,8'h5A));
        vq.push_back(mk(0,8'h00,0,8'h00, 0,8'h00,0,8'h00,
                        0,1,8'h00,0,8'h00,8'h00,8'h64,8'h5A));
        // tie: m0 first (last=1), four cycles each, m1 write blocked
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        0,0,8'h00,0,8'h00,8'h00,8'h00,8'h5A));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        1,0,8'h01,0,8'h00,8'h00,8'h00,8'h5A));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        1,0,8'h01,0,8'h00,8'h14,8'h00,8'h5A));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        1,0,8'h01,0,8'h00,8'h14,8'h00,8'h5A));
        vq.push_back(mk(1,8'h03,0,8'h00, 1,8'h80,1,8'h77,
                        1,0,8'h03,0,8'h00,8'h14,8'h00,8'h5A));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        0,1,8'h80,1,8'h77,8'h3C,8'h00,8'h5A));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        0,1,8'h80,1,8'h77,8'h00,8'h5A,8'h77));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        0,1,8'h80,1,8'h77,8'h00,8'h77,8'h77));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        0,1,8'h80,1,8'h77,8'h00,8'h77,8'h77));
        vq.push_back(mk(1,8'h01,0,8'h00, 1,8'h80,1,8'h77,
                        1,0,8'h01,0,8'h00,8'h00,8'h77,8'h77));

        reset = 1'b0;
        mdl_init = 1'b1;
        drive(0,8'h00,0,8'h00, 0,8'h00,0,8'h00);
        #1;
        chk("reset_outputs",
            {m0_grant, m1_grant, bus_addr, bus_write_en, bus_data_out,
             m0_data_in, m1_data_in}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mdl_init = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].m0r, vq[i].m0a, vq[i].m0w, vq[i].m0d,
                  vq[i].m1r, vq[i].m1a, vq[i].m1w, vq[i].m1d);
            #1;
            chk($sformatf("vec%0d", i),
                {m0_grant, m1_grant, bus_addr, bus_write_en,
                 bus_data_out, m0_data_in, m1_data_in, gpio_q},
                {vq[i].eg0, vq[i].eg1, vq[i].ea, vq[i].ew,
                 vq[i].ed, vq[i].e0, vq[i].e1, vq[i].eio});
        end

        // handover to m1 writing GPIO, then reset in the middle of it
        @(negedge clk);
        drive(0,8'h00,0,8'h00, 1,8'h80,1,8'h33);
        @(negedge clk);
        #1;
        chk("own1_write", {m1_grant, bus_write_en, bus_addr}, {2'b11, 8'h80});
        @(negedge clk);
        #1;
        chk("own1_readback", m1_data_in, 8'h77);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs",
            {m0_grant, m1_grant, bus_addr, bus_write_en, bus_data_out,
             m0_data_in, m1_data_in}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1,8'h00,0,8'h00, 0,8'h00,0,8'h00);
        #1;
        chk("post_reset_idle", {m0_grant, m1_grant}, 2'b00);
        @(negedge clk);
        #1;
        chk("post_reset_m0", {m0_grant, m1_grant}, 2'b10);

        // MAX_HOLD=1 instance alternates every cycle under contention
        @(negedge clk);
        drive(1,8'h01,0,8'h00, 1,8'h02,0,8'h00);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("hold1_cyc%0d", k),
                {h_g0, h_g1, h_ba, h_bwe},
                (k % 2 == 0) ? {2'b10, 8'h01, 1'b0}
                             : {2'b01, 8'h02, 1'b0});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
